// File: rtl/srdl_access_arbiter.sv
// Two-requester access arbiter for a register block.
// Round-robin between host (m0) and debug (m1); one access in flight at a time.
// Range-checks the address, waits RD_LAT cycles for read data, and returns
// the result on a per-requester response handshake.
module srdl_access_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rsp_vld,
  output logic [DW-1:0] m0_rsp_rdata,
  output logic          m0_rsp_err,
  input  logic          m0_rsp_rdy,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rsp_vld,
  output logic [DW-1:0] m1_rsp_rdata,
  output logic          m1_rsp_err,
  input  logic          m1_rsp_rdy,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_acc,
  output logic          reg_rd,
  output logic          reg_wr,
  input  logic [DW-1:0] reg_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [AW:0] NREGS_W  = (AW+1)'(NUM_REGS);
  localparam bit          LAT_ZERO = (RD_LAT == 0);
  localparam logic [2:0]  LAT_M1   = LAT_ZERO ? 3'd0 : 3'(RD_LAT - 1);

  state_t          state_q, state_d;
  logic            last_gnt_q;
  logic            cap_id_q;
  logic            cap_we_q;
  logic [AW-1:0]   cap_addr_q;
  logic [DW-1:0]   cap_wdata_q;
  logic [2:0]      cnt_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;

  logic            grant;
  logic            sel_id;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            in_range;
  logic            sel_rsp_rdy;
  logic            in_resp;

  // Arbitration: a lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    grant     = (state_q == IDLE) && (m0_req || m1_req);
    sel_id    = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
    sel_we    = sel_id ? m1_we    : m0_we;
    sel_addr  = sel_id ? m1_addr  : m0_addr;
    sel_wdata = sel_id ? m1_wdata : m0_wdata;
  end

  assign in_range    = {1'b0, cap_addr_q} < NREGS_W;
  assign sel_rsp_rdy = cap_id_q ? m1_rsp_rdy : m0_rsp_rdy;
  assign in_resp     = (state_q == RESP);

  // Grant pulses are masked while reset is held so every output reads 0 in reset.
  assign m0_gnt = rst_l & grant & ~sel_id;
  assign m1_gnt = rst_l & grant &  sel_id;

  assign reg_addr  = cap_addr_q;
  assign reg_wdata = cap_wdata_q;
  assign reg_acc   = (state_q == ISSUE) && in_range;
  assign reg_wr    = reg_acc &&  cap_we_q;
  assign reg_rd    = reg_acc && !cap_we_q;

  assign m0_rsp_vld   = in_resp && !cap_id_q;
  assign m1_rsp_vld   = in_resp &&  cap_id_q;
  assign m0_rsp_rdata = m0_rsp_vld ? rsp_rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_vld ? rsp_rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_vld & rsp_err_q;
  assign m1_rsp_err   = m1_rsp_vld & rsp_err_q;

  // Next-state: issue for one cycle, optionally wait out read latency, then respond.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = (!in_range || cap_we_q || LAT_ZERO) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (sel_rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, round-robin pointer, latency counter and response payload.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_gnt_q  <= 1'b1;
      cap_id_q    <= 1'b0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (grant) begin
        cap_id_q    <= sel_id;
        cap_we_q    <= sel_we;
        cap_addr_q  <= sel_addr;
        cap_wdata_q <= sel_wdata;
        last_gnt_q  <= sel_id;
      end
      case (state_q)
        ISSUE: begin
          if (!in_range) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            rsp_err_q <= 1'b0;
            if (cap_we_q)      rsp_rdata_q <= '0;
            else if (LAT_ZERO) rsp_rdata_q <= reg_rdata;
            else               cnt_q       <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) rsp_rdata_q <= reg_rdata;
          else             cnt_q       <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
